bram_burst_reader: RTL and testbench

// - Initiator on one port of the dual-port BRAM: reads a burst of consecutive words and streams them out over valid/ready.
// - Absorbs the BRAM's 1-cycle registered read latency so the stream sustains 1 word/cycle and tolerates arbitrary backpressure.
// - Used by testbench/loader logic to dump data/instruction memory; the write side of the BRAM port is left idle (top ties we=0).

---
 rtl/bram_rd_pkg.sv | 14 +
 rtl/bram_burst_reader_if.sv | 15 +
 rtl/bram_rd_skid.sv | 72 +++++++
 rtl/bram_burst_reader.sv | 134 +++++++++++++
 tb/tb_bram_burst_reader.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/bram_rd_pkg.sv
`timescale 1ns/1ps
// Shared types and sizing for the BRAM burst reader and its skid FIFO.
package bram_rd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } rd_state_t;

  localparam int SKID_DEPTH = 2;
  localparam int SKID_CW    = $clog2(SKID_DEPTH + 1);

endpackage

// File: rtl/bram_burst_reader_if.sv
`timescale 1ns/1ps
// Output word stream of the burst reader.
// A word transfers on a clock edge where po_tvalid & pi_tready; while
// po_tvalid is high and pi_tready low, po_tdata/po_tlast stay unchanged.
interface bram_burst_reader_if #(
  parameter int WDATA = 32
) ();
  logic [WDATA-1:0] po_tdata;
  logic             po_tvalid;
  logic             po_tlast;
  logic             pi_tready;

  modport master (output po_tdata, output po_tvalid, output po_tlast, input pi_tready);
  modport slave  (input po_tdata, input po_tvalid, input po_tlast, output pi_tready);
endinterface

// File: rtl/bram_rd_skid.sv
`timescale 1ns/1ps
// Two-entry FIFO that catches BRAM read data; the head entry is held in
// registers that drive the stream directly.
module bram_rd_skid
  import bram_rd_pkg::*;
#(
  parameter int WDATA = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               push,
  input  logic [WDATA-1:0]   push_data,
  input  logic               push_last,
  input  logic               pop,
  output logic [SKID_CW-1:0] count,
  output logic [WDATA-1:0]   out_data,
  output logic               out_last,
  output logic               out_valid
);

  localparam logic [SKID_CW-1:0] CNT_ONE = SKID_CW'(1);

  logic [WDATA-1:0] d1;
  logic             l1;

  assign out_valid = (count != '0);

  // Head entry only changes on pop or when a push lands in an empty FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      out_data <= '0;
      out_last <= 1'b0;
      d1       <= '0;
      l1       <= 1'b0;
    end else if (flush) begin
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == '0) begin
            out_data <= push_data;
            out_last <= push_last;
          end else begin
            d1 <= push_data;
            l1 <= push_last;
          end
          count <= count + CNT_ONE;
        end
        2'b01: begin
          out_data <= d1;
          out_last <= l1;
          count    <= count - CNT_ONE;
        end
        2'b11: begin
          if (count == CNT_ONE) begin
            out_data <= push_data;
            out_last <= push_last;
          end else begin
            out_data <= d1;
            out_last <= l1;
            d1       <= push_data;
            l1       <= push_last;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/bram_burst_reader.sv
`timescale 1ns/1ps
// Reads a burst of consecutive BRAM words and streams them over valid/ready,
// hiding the one-cycle BRAM read latency behind a two-entry skid FIFO.
module bram_burst_reader
  import bram_rd_pkg::*;
#(
  parameter int WADDR = 10,
  parameter int WDATA = 32
) (
  input  logic                  pi_clk,
  input  logic                  pi_rst_n,
  input  logic                  pi_start,
  input  logic [WADDR-1:0]      pi_base_addr,
  input  logic [WADDR:0]        pi_len,
  input  logic                  pi_abort,
  output logic                  po_busy,
  output logic                  po_done,
  output logic                  po_bram_en,
  output logic [WADDR-1:0]      po_bram_addr,
  input  logic [WDATA-1:0]      pi_bram_do,
  bram_burst_reader_if.master   axis,
  output rd_state_t             po_dbg_state
);

  localparam logic [WADDR:0]   LEN_ONE  = (WADDR+1)'(1);
  localparam logic [WADDR-1:0] ADDR_ONE = WADDR'(1);

  rd_state_t            state_q, state_d;
  logic [WADDR-1:0]     addr_q;
  logic [WADDR:0]       remaining_q;
  logic                 inflight_q;
  logic                 inflight_last_q;
  logic                 done_q, done_d;
  logic                 flush;
  logic                 pop;
  logic                 abort_now;
  logic                 issue_ok;
  logic [2:0]           occ;
  logic [SKID_CW-1:0]   skid_count;
  logic [WDATA-1:0]     skid_data;
  logic                 skid_last;
  logic                 skid_valid;

  assign pop       = skid_valid & axis.pi_tready;
  assign abort_now = pi_abort & (state_q != ST_IDLE);
  assign occ       = {1'b0, skid_count} + {2'b00, inflight_q};
  // Issue only if the word will have a FIFO slot once it lands.
  assign issue_ok  = (occ < 3'd2) || ((occ == 3'd2) && pop);

  always_comb begin
    state_d    = state_q;
    done_d     = 1'b0;
    flush      = 1'b0;
    po_bram_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pi_start) begin
          if (pi_len != '0) state_d = ST_READ;
          else              done_d  = 1'b1;
        end
      end
      ST_READ: begin
        po_bram_en = issue_ok;
        if (pi_abort) begin
          state_d = ST_IDLE;
          flush   = 1'b1;
        end else if (issue_ok && (remaining_q == LEN_ONE)) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (pi_abort) begin
          state_d = ST_IDLE;
          flush   = 1'b1;
        end else if (pop && skid_last) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge pi_clk or negedge pi_rst_n) begin
    if (!pi_rst_n) begin
      state_q         <= ST_IDLE;
      done_q          <= 1'b0;
      addr_q          <= '0;
      remaining_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      if ((state_q == ST_IDLE) && pi_start && (pi_len != '0)) begin
        addr_q      <= pi_base_addr;
        remaining_q <= pi_len;
        inflight_q  <= 1'b0;
      end else if (abort_now) begin
        inflight_q <= 1'b0;
      end else begin
        if (po_bram_en) begin
          addr_q          <= addr_q + ADDR_ONE;
          remaining_q     <= remaining_q - LEN_ONE;
          inflight_last_q <= (remaining_q == LEN_ONE);
        end
        inflight_q <= po_bram_en;
      end
    end
  end

  bram_rd_skid #(.WDATA(WDATA)) u_skid (
    .clk       (pi_clk),
    .rst_n     (pi_rst_n),
    .flush     (flush),
    .push      (inflight_q),
    .push_data (pi_bram_do),
    .push_last (inflight_last_q),
    .pop       (pop),
    .count     (skid_count),
    .out_data  (skid_data),
    .out_last  (skid_last),
    .out_valid (skid_valid)
  );

  assign po_busy        = (state_q != ST_IDLE);
  assign po_done        = done_q;
  assign po_bram_addr   = addr_q;
  assign po_dbg_state   = state_q;
  assign axis.po_tdata  = skid_data;
  assign axis.po_tvalid = skid_valid;
  assign axis.po_tlast  = skid_valid & skid_last;

endmodule

// File: tb/tb_bram_burst_reader.sv
`timescale 1ns/1ps
// Bench for bram_burst_reader: BRAM model, random backpressure, word-level
// scoreboard built from base/len, plus abort and async-reset scenarios.
module tb_bram_burst_reader;
  import bram_rd_pkg::*;

  localparam int WADDR = 10;
  localparam int WDATA = 32;
  localparam int DEPTH = 1 << WADDR;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic               start, abort, tready;
  logic [WADDR-1:0]   base;
  logic [WADDR:0]     len;
  logic               busy, done, en;
  logic [WADDR-1:0]   baddr;
  logic [WDATA-1:0]   bdo = '0;
  rd_state_t          dbg_state;
  logic [WDATA-1:0]   tdata;
  logic               tvalid, tlast;

  bram_burst_reader_if #(.WDATA(WDATA)) axis ();
  assign axis.pi_tready = tready;
  assign tdata  = axis.po_tdata;
  assign tvalid = axis.po_tvalid;
  assign tlast  = axis.po_tlast;

  bram_burst_reader #(.WADDR(WADDR), .WDATA(WDATA)) dut (
    .pi_clk       (clk),
    .pi_rst_n     (rst_n),
    .pi_start     (start),
    .pi_base_addr (base),
    .pi_len       (len),
    .pi_abort     (abort),
    .po_busy      (busy),
    .po_done      (done),
    .po_bram_en   (en),
    .po_bram_addr (baddr),
    .pi_bram_do   (bdo),
    .axis         (axis),
    .po_dbg_state (dbg_state)
  );

  // BRAM model: registered read, output held while en=0
  logic [WDATA-1:0] ram [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) ram[i] = WDATA'(i + 32'h100);
  always @(posedge clk) if (en) bdo <= ram[baddr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state
  logic [WDATA:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int start_cyc, cur_base, cur_len, issued, outstanding;
  int ready_mode = 0;
  bit first_pending = 0, zero_len_pend = 0, prev_final_pop = 0, prev_stall = 0;
  logic [WDATA-1:0] prev_data;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // backpressure driver
  initial begin
    tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: tready = 1'b1;
        1: tready = 1'($urandom_range(0, 1));
        default: tready = 1'b0;
      endcase
    end
  end

  // monitor / scoreboard, sampled on the falling edge
  always @(negedge clk) begin : mon
    logic exp_done;
    logic pop;
    logic [WDATA:0] e;
    if (!rst_n) begin
      exp_q.delete();
      outstanding = 0; issued = 0; cur_len = 0;
      first_pending = 0; zero_len_pend = 0; prev_final_pop = 0; prev_stall = 0;
    end else begin
      exp_done = prev_final_pop | zero_len_pend;
      zero_len_pend = 0;
      prev_final_pop = 0;
      if (done || exp_done) begin
        check("done_pulse", done, exp_done);
        if (exp_done) check("busy_at_done", busy, 0);
      end
      if (prev_stall) begin
        check("hold_valid", tvalid, 1);
        check("hold_data", tdata, prev_data);
      end
      if (first_pending && tvalid) begin
        check("first_latency", cyc - start_cyc, 2);
        first_pending = 0;
      end
      if (abort) begin
        exp_q.delete();
        outstanding = 0; issued = 0; cur_len = 0;
        first_pending = 0; prev_stall = 0;
      end else begin
        pop = tvalid & tready;
        if (en) begin
          check("en_within_len", issued < cur_len, 1);
          check("en_no_overrun", (outstanding == 2) && !pop, 0);
          check("bram_addr", baddr, (cur_base + issued) % DEPTH);
          issued++;
          outstanding++;
        end
        if (pop) begin
          if (exp_q.size() == 0) begin
            check("extra_word", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("tdata", tdata, e[WDATA-1:0]);
            check("tlast", tlast, e[WDATA]);
            prev_final_pop = e[WDATA];
            outstanding--;
          end
        end
        prev_stall = tvalid & !tready;
        prev_data  = tdata;
      end
    end
  end

  task automatic start_burst(input int b, input int l);
    cur_base = b;
    cur_len  = l;
    issued   = 0;
    for (int i = 0; i < l; i++)
      exp_q.push_back({(i == l - 1), WDATA'(((b + i) % DEPTH) + 32'h100)});
    @(posedge clk); #1;
    start = 1'b1;
    base  = WADDR'(b);
    len   = (WADDR+1)'(l);
    @(posedge clk); #1;
    start     = 1'b0;
    start_cyc = cyc;
    if (l == 0) zero_len_pend = 1;
    else        first_pending = 1;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("timeout", n >= budget, 0);
    repeat (2) @(negedge clk);
    #1;
    check("idle_busy", busy, 0);
    check("idle_tvalid", tvalid, 0);
    check("idle_words_left", exp_q.size(), 0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_en"}, en, 0);
    check({tag, "_tvalid"}, tvalid, 0);
    check({tag, "_tlast"}, tlast, 0);
    check({tag, "_addr"}, baddr, 0);
    check({tag, "_tdata"}, tdata, 0);
    check({tag, "_state"}, dbg_state, ST_IDLE);
  endtask

  task automatic finish_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  initial begin
    #2_000_000;
    check("watchdog", 1, 0);
    finish_run();
  end

  initial begin
    start = 1'b0; abort = 1'b0; base = '0; len = '0;
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    rst_n = 1'b1;

    // basic burst, full throughput
    ready_mode = 0;
    start_burst(4, 8);
    wait_idle(100);

    // address wrap
    start_burst(1022, 4);
    wait_idle(100);

    // random backpressure, with a start attempt while busy
    ready_mode = 1;
    start_burst(100, 16);
    repeat (3) @(posedge clk);
    #1;
    check("busy_before_ignored_start", busy, 1);
    start = 1'b1; base = 10'd7; len = 11'd3;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle(400);

    // zero length
    ready_mode = 0;
    start_burst(5, 0);
    wait_idle(20);

    // whole memory, starting mid-array
    start_burst(517, DEPTH);
    wait_idle(3000);

    // random bursts
    ready_mode = 1;
    for (int k = 0; k < 4; k++) begin
      start_burst(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, 24)));
      wait_idle(400);
    end

    // abort under stall
    ready_mode = 2;
    @(posedge clk);
    start_burst(300, 10);
    repeat (3) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_tvalid", tvalid, 0);
    check("abort_busy", busy, 0);
    repeat (3) @(negedge clk);
    ready_mode = 0;
    start_burst(0, 2);
    wait_idle(100);

    // async reset mid-burst
    start_burst(50, 16);
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("async_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    start_burst(200, 5);
    wait_idle(100);

    finish_run();
  end

endmodule
